// File: rtl/evm_pkg.sv
// Shared types and default parameters for the electronic voting machine ballot controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package evm_pkg;

    // Ballot controller states
    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        IDLE   = 2'd1,
        ARMED  = 2'd2,
        HOLD   = 2'd3
    } evm_state_t;

    localparam int EVM_N_CAND  = 2;   // candidate buttons
    localparam int EVM_CNT_W   = 4;   // audit counter width
    localparam int EVM_TIMEOUT = 16;  // cycles a ballot stays armed, >= 2

endpackage

// File: rtl/evm_sat_counter.sv
// Saturating up-counter used for the ballot/cast/lapse audit counts.
// Latency: count reflects inc_i one edge later.
// Backpressure: none; increments at all-ones are dropped (counter holds).
// Ports: clk_i, rst_n_i (sync active-low), inc_i (increment strobe), cnt_o (count).
module evm_sat_counter
    import evm_pkg::*;
#(
    parameter int CNT_W = EVM_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot controller: issues one ballot at a time, accepts one clean vote per ballot, lapses stale ballots.
// Latency: ballot_req rise -> enable_o next edge; accepted vote rise -> vote_inc_o next edge.
// Backpressure: none; button edges outside ARMED/IDLE are ignored, held buttons block re-arming via HOLD.
// Ports: clk_i, rst_n_i (sync active-low), voting_status_i, ballot_req_i, vote_i[N_CAND];
//        enable_o, vote_inc_o[N_CAND], multi_err_o, ballot_cnt_o, cast_cnt_o, lapse_cnt_o.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int N_CAND  = EVM_N_CAND,
    parameter int CNT_W   = EVM_CNT_W,
    parameter int TIMEOUT = EVM_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              voting_status_i,
    input  logic              ballot_req_i,
    input  logic [N_CAND-1:0] vote_i,
    output logic              enable_o,
    output logic [N_CAND-1:0] vote_inc_o,
    output logic              multi_err_o,
    output logic [CNT_W-1:0]  ballot_cnt_o,
    output logic [CNT_W-1:0]  cast_cnt_o,
    output logic [CNT_W-1:0]  lapse_cnt_o
);

    localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    evm_state_t        state_q;
    logic [TMR_W-1:0]  timer_q;
    logic              enable_q;
    logic [N_CAND-1:0] vote_inc_q;
    logic              multi_err_q;
    logic [N_CAND-1:0] vote_q;
    logic              ballot_req_q;

    logic [N_CAND-1:0] vote_rise;
    logic              ballot_rise;
    logic              vote_multi;
    logic              vote_one;
    logic              timer_done;
    logic              ballot_inc;
    logic              cast_inc;
    logic              lapse_inc;

    assign vote_rise   = vote_i & ~vote_q;
    assign ballot_rise = ballot_req_i & ~ballot_req_q;
    // Clearing the lowest set bit leaves something only if two or more bits rose.
    assign vote_multi  = (vote_rise & (vote_rise - N_CAND'(1))) != '0;
    assign vote_one    = (vote_rise != '0) && !vote_multi;
    assign timer_done  = (timer_q == TMR_LAST);

    // Poll close overrides every other event on the same edge.
    assign ballot_inc = voting_status_i && (state_q == IDLE) && ballot_rise && (vote_i == '0);
    assign cast_inc   = voting_status_i && (state_q == ARMED) && vote_one;
    // A clean vote on the timeout edge wins over the lapse.
    assign lapse_inc  = (state_q == ARMED) &&
                        (!voting_status_i || (timer_done && !vote_one));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= CLOSED;
            timer_q      <= '0;
            enable_q     <= 1'b0;
            vote_inc_q   <= '0;
            multi_err_q  <= 1'b0;
            vote_q       <= '0;
            ballot_req_q <= 1'b0;
        end else begin
            vote_q       <= vote_i;
            ballot_req_q <= ballot_req_i;
            vote_inc_q   <= '0;
            multi_err_q  <= 1'b0;
            if (!voting_status_i) begin
                state_q  <= CLOSED;
                enable_q <= 1'b0;
            end else begin
                case (state_q)
                    CLOSED: state_q <= IDLE;
                    IDLE: begin
                        if (ballot_inc) begin
                            state_q  <= ARMED;
                            enable_q <= 1'b1;
                            timer_q  <= '0;
                        end
                    end
                    ARMED: begin
                        timer_q <= timer_q + TMR_W'(1);
                        if (vote_one) begin
                            state_q    <= HOLD;
                            enable_q   <= 1'b0;
                            vote_inc_q <= vote_rise;
                        end else if (timer_done) begin
                            state_q  <= HOLD;
                            enable_q <= 1'b0;
                        end
                        if (vote_multi) begin
                            multi_err_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        // Wait for all buttons released so a held button cannot vote next ballot.
                        if (vote_i == '0) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= CLOSED;
                endcase
            end
        end
    end

    evm_sat_counter #(.CNT_W(CNT_W)) u_ballot_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (ballot_inc),
        .cnt_o   (ballot_cnt_o)
    );

    evm_sat_counter #(.CNT_W(CNT_W)) u_cast_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (cast_inc),
        .cnt_o   (cast_cnt_o)
    );

    evm_sat_counter #(.CNT_W(CNT_W)) u_lapse_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (lapse_inc),
        .cnt_o   (lapse_cnt_o)
    );

    assign enable_o    = enable_q;
    assign vote_inc_o  = vote_inc_q;
    assign multi_err_o = multi_err_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed bench for evm_ballot_ctrl with default parameters (2 candidates, 4-bit counts, timeout 16).
// Latency: n/a.
// Backpressure: n/a.
module tb_evm_ballot_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       voting_status_i;
    logic       ballot_req_i;
    logic [1:0] vote_i;
    logic       enable_o;
    logic [1:0] vote_inc_o;
    logic       multi_err_o;
    logic [3:0] ballot_cnt_o;
    logic [3:0] cast_cnt_o;
    logic [3:0] lapse_cnt_o;

    int total = 0;
    int bad   = 0;

    evm_ballot_ctrl #(.N_CAND(2), .CNT_W(4), .TIMEOUT(16)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .voting_status_i (voting_status_i),
        .ballot_req_i    (ballot_req_i),
        .vote_i          (vote_i),
        .enable_o        (enable_o),
        .vote_inc_o      (vote_inc_o),
        .multi_err_o     (multi_err_o),
        .ballot_cnt_o    (ballot_cnt_o),
        .cast_cnt_o      (cast_cnt_o),
        .lapse_cnt_o     (lapse_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge; outputs are then stable and inputs may change.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i         = 1'b0;
        voting_status_i = 1'b0;
        ballot_req_i    = 1'b0;
        vote_i          = 2'b00;
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    // Open the poll and arm one ballot; returns with ballot_req released.
    task automatic open_and_arm();
        voting_status_i = 1'b1;
        tick();
        ballot_req_i = 1'b1;
        tick();
        ballot_req_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL reset_enable got=%b exp=0", enable_o); end
        total++; if (vote_inc_o !== 2'b00) begin bad++; $display("FAIL reset_vote_inc got=%b exp=00", vote_inc_o); end
        total++; if (multi_err_o !== 1'b0) begin bad++; $display("FAIL reset_multi got=%b exp=0", multi_err_o); end
        total++; if ({ballot_cnt_o, cast_cnt_o, lapse_cnt_o} !== 12'h000) begin
            bad++; $display("FAIL reset_counts got=%h/%h/%h exp=0/0/0", ballot_cnt_o, cast_cnt_o, lapse_cnt_o);
        end
    endtask

    task automatic test_basic_vote();
        do_reset();
        voting_status_i = 1'b1;
        tick();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL basic_idle_enable got=%b exp=0", enable_o); end
        ballot_req_i = 1'b1;
        tick();
        total++; if (enable_o !== 1'b1) begin bad++; $display("FAIL basic_arm_enable got=%b exp=1", enable_o); end
        total++; if (ballot_cnt_o !== 4'd1) begin bad++; $display("FAIL basic_ballot_cnt got=%0d exp=1", ballot_cnt_o); end
        ballot_req_i = 1'b0;
        tick();
        tick();
        vote_i = 2'b01;
        tick();
        total++; if (vote_inc_o !== 2'b01) begin bad++; $display("FAIL basic_vote_inc got=%b exp=01", vote_inc_o); end
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL basic_vote_enable got=%b exp=0", enable_o); end
        total++; if (cast_cnt_o !== 4'd1) begin bad++; $display("FAIL basic_cast_cnt got=%0d exp=1", cast_cnt_o); end
        tick();
        total++; if (vote_inc_o !== 2'b00) begin bad++; $display("FAIL basic_vote_inc_width got=%b exp=00", vote_inc_o); end
        vote_i = 2'b00;
        tick();
    endtask

    task automatic test_multi_press();
        do_reset();
        open_and_arm();
        vote_i = 2'b11;
        tick();
        total++; if (multi_err_o !== 1'b1) begin bad++; $display("FAIL multi_pulse got=%b exp=1", multi_err_o); end
        total++; if (vote_inc_o !== 2'b00) begin bad++; $display("FAIL multi_no_inc got=%b exp=00", vote_inc_o); end
        total++; if (enable_o !== 1'b1) begin bad++; $display("FAIL multi_still_armed got=%b exp=1", enable_o); end
        tick();
        total++; if (multi_err_o !== 1'b0) begin bad++; $display("FAIL multi_one_cycle got=%b exp=0", multi_err_o); end
        vote_i = 2'b00;
        tick();
        vote_i = 2'b10;
        tick();
        total++; if (vote_inc_o !== 2'b10) begin bad++; $display("FAIL multi_then_vote got=%b exp=10", vote_inc_o); end
        total++; if (cast_cnt_o !== 4'd1) begin bad++; $display("FAIL multi_cast_cnt got=%0d exp=1", cast_cnt_o); end
        total++; if (multi_err_o !== 1'b0) begin bad++; $display("FAIL multi_no_second got=%b exp=0", multi_err_o); end
        vote_i = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        int inc_seen;
        int early_drop;
        inc_seen   = 0;
        early_drop = 0;
        do_reset();
        open_and_arm();
        // Armed at edge k; enable must survive edges k+1 .. k+15.
        for (int i = 1; i < 16; i++) begin
            tick();
            if (enable_o !== 1'b1) early_drop++;
            if (vote_inc_o !== 2'b00) inc_seen++;
        end
        total++; if (early_drop !== 0) begin bad++; $display("FAIL timeout_early got=%0d drops exp=0", early_drop); end
        tick();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL timeout_edge16 got=%b exp=0", enable_o); end
        total++; if (lapse_cnt_o !== 4'd1) begin bad++; $display("FAIL timeout_lapse_cnt got=%0d exp=1", lapse_cnt_o); end
        if (vote_inc_o !== 2'b00) inc_seen++;
        tick();
        if (vote_inc_o !== 2'b00) inc_seen++;
        total++; if (inc_seen !== 0) begin bad++; $display("FAIL timeout_no_inc got=%0d exp=0", inc_seen); end
        total++; if (cast_cnt_o !== 4'd0) begin bad++; $display("FAIL timeout_cast_cnt got=%0d exp=0", cast_cnt_o); end
    endtask

    task automatic test_held_vote();
        do_reset();
        open_and_arm();
        // Double press then release one button: bit 0 stays held without a new rise.
        vote_i = 2'b11;
        tick();
        vote_i = 2'b01;
        for (int i = 2; i < 16; i++) tick();
        total++; if (enable_o !== 1'b1) begin bad++; $display("FAIL held_armed_k15 got=%b exp=1", enable_o); end
        tick();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL held_lapse got=%b exp=0", enable_o); end
        total++; if (lapse_cnt_o !== 4'd1) begin bad++; $display("FAIL held_lapse_cnt got=%0d exp=1", lapse_cnt_o); end
        ballot_req_i = 1'b1;
        tick();
        ballot_req_i = 1'b0;
        tick();
        tick();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL held_no_rearm got=%b exp=0", enable_o); end
        total++; if (ballot_cnt_o !== 4'd1) begin bad++; $display("FAIL held_ballot_cnt got=%0d exp=1", ballot_cnt_o); end
        vote_i = 2'b00;
        tick();
        ballot_req_i = 1'b1;
        tick();
        ballot_req_i = 1'b0;
        total++; if (enable_o !== 1'b1) begin bad++; $display("FAIL held_rearm got=%b exp=1", enable_o); end
        total++; if (ballot_cnt_o !== 4'd2) begin bad++; $display("FAIL held_ballot_cnt2 got=%0d exp=2", ballot_cnt_o); end
        vote_i = 2'b01;
        tick();
        total++; if (vote_inc_o !== 2'b01) begin bad++; $display("FAIL held_next_vote got=%b exp=01", vote_inc_o); end
        vote_i = 2'b00;
        tick();
    endtask

    task automatic test_close_vote();
        do_reset();
        open_and_arm();
        tick();
        vote_i          = 2'b01;
        voting_status_i = 1'b0;
        tick();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL close_enable got=%b exp=0", enable_o); end
        total++; if (vote_inc_o !== 2'b00) begin bad++; $display("FAIL close_vote_inc got=%b exp=00", vote_inc_o); end
        total++; if (lapse_cnt_o !== 4'd1) begin bad++; $display("FAIL close_lapse_cnt got=%0d exp=1", lapse_cnt_o); end
        total++; if (cast_cnt_o !== 4'd0) begin bad++; $display("FAIL close_cast_cnt got=%0d exp=0", cast_cnt_o); end
        // Closed: ballot requests and votes are ignored.
        vote_i       = 2'b00;
        ballot_req_i = 1'b1;
        tick();
        ballot_req_i = 1'b0;
        vote_i       = 2'b10;
        tick();
        total++; if (enable_o !== 1'b0) begin bad++; $display("FAIL close_locked got=%b exp=0", enable_o); end
        total++; if (ballot_cnt_o !== 4'd1) begin bad++; $display("FAIL close_ballot_cnt got=%0d exp=1", ballot_cnt_o); end
        total++; if (vote_inc_o !== 2'b00) begin bad++; $display("FAIL close_vote_ignored got=%b exp=00", vote_inc_o); end
        vote_i = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        open_and_arm();
        vote_i  = 2'b10;
        rst_n_i = 1'b0;
        tick();
        total++; if ({enable_o, vote_inc_o} !== 3'b000) begin
            bad++; $display("FAIL rstmid_outputs got=%b%b exp=000", enable_o, vote_inc_o);
        end
        total++; if ({ballot_cnt_o, cast_cnt_o, lapse_cnt_o} !== 12'h000) begin
            bad++; $display("FAIL rstmid_counts got=%h/%h/%h exp=0/0/0", ballot_cnt_o, cast_cnt_o, lapse_cnt_o);
        end
        rst_n_i = 1'b1;
        vote_i  = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        int         inc_cnt;
        logic [1:0] pick;
        inc_cnt = 0;
        do_reset();
        voting_status_i = 1'b1;
        tick();
        for (int b = 0; b < 17; b++) begin
            pick         = (b % 2 == 0) ? 2'b01 : 2'b10;
            ballot_req_i = 1'b1;
            tick();
            ballot_req_i = 1'b0;
            vote_i       = pick;
            tick();
            if (vote_inc_o === pick) inc_cnt++;
            vote_i = 2'b00;
            tick();
        end
        total++; if (inc_cnt !== 17) begin bad++; $display("FAIL b2b_inc_pulses got=%0d exp=17", inc_cnt); end
        total++; if (ballot_cnt_o !== 4'd15) begin bad++; $display("FAIL b2b_ballot_sat got=%0d exp=15", ballot_cnt_o); end
        total++; if (cast_cnt_o !== 4'd15) begin bad++; $display("FAIL b2b_cast_sat got=%0d exp=15", cast_cnt_o); end
        total++; if (lapse_cnt_o !== 4'd0) begin bad++; $display("FAIL b2b_lapse got=%0d exp=0", lapse_cnt_o); end
    endtask

    initial begin
        rst_n_i         = 1'b0;
        voting_status_i = 1'b0;
        ballot_req_i    = 1'b0;
        vote_i          = 2'b00;
        test_reset();
        test_basic_vote();
        test_multi_press();
        test_timeout();
        test_held_vote();
        test_close_vote();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/evm_ballot_ctrl.md
# evm_ballot_ctrl

Ballot controller for the electronic voting machine. It sits between the presiding officer's ballot button, the candidate vote buttons and the per-candidate tally counters. It issues one ballot at a time and accepts exactly one clean vote per ballot. It expires unused ballots and locks the machine whenever polling is closed. It also keeps audit counts of ballots issued, votes cast and ballots lapsed.

## Interface
- `N_CAND`, default 2: number of candidate buttons.
- `CNT_W`, default 4: width of each audit counter.
- `TIMEOUT`, default 16: number of cycles a ballot stays armed without a vote; must be ≥ 2.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `voting_status`  in  1  poll open (1) or closed (0); level.
- `ballot_req`  in  1  officer's ballot button; level, rising edge detected internally.
- `vote`  in  `N_CAND`  candidate buttons; level, bit i belongs to candidate i.
- `enable`  out  1  ballot armed; drives the voter-facing ready lamp.
- `vote_inc`  out  `N_CAND`  one-hot increment strobe to the tally counters, one cycle wide.
- `multi_err`  out  1  one-cycle pulse when two or more buttons rise together.
- `ballot_cnt`  out  `CNT_W`  ballots issued.
- `cast_cnt`  out  `CNT_W`  votes accepted.
- `lapse_cnt`  out  `CNT_W`  ballots expired or voided at poll close.

## Operation
- States: CLOSED, IDLE, ARMED, HOLD.
- CLOSED → IDLE when `voting_status`=1.
- IDLE → ARMED on a `ballot_req` rising edge, but only when `vote`=0.
  - Entering ARMED sets `enable`=1 and increments `ballot_cnt`.
- ARMED, exactly one bit of `vote` rising (`vote & ~vote_q` is one-hot):
  - next state HOLD, `enable`=0;
  - `vote_inc` = that bit for one cycle; `cast_cnt`++.
- ARMED, two or more bits rising in the same cycle:
  - pulse `multi_err`, no `vote_inc`, stay ARMED;
  - the timer keeps running.
- ARMED, timer reaches `TIMEOUT`-1 with no accepted vote: `lapse_cnt`++, `enable`=0, go to HOLD.
- HOLD → IDLE once `vote`=0. This prevents a held button from voting on the next ballot.
- `voting_status`=0 in any state → CLOSED on the next edge.
  - If the state was ARMED, `enable`=0 and `lapse_cnt`++.
  - A vote rising on that same edge is discarded.
- In IDLE and CLOSED:
  - `vote` edges are ignored.
  - `ballot_req` edges are ignored outside IDLE.
- Audit counters saturate at 2^`CNT_W`-1 and are never cleared except by reset.

## Timing
- All outputs are registered.
- Reset values:
  - state = CLOSED;
  - `enable`, `vote_inc`, `multi_err` = 0;
  - all counters = 0;
  - `vote_q`, `ballot_req_q` = 0.
- Edge detection compares inputs with their value registered one cycle earlier. An input first sampled high at edge k counts as a rising edge at edge k.
- Ballot latency: a `ballot_req` rising edge at edge k gives `enable`=1 after edge k.
- Vote latency: an accepted vote rising at edge k gives `vote_inc` high for the cycle after edge k, and `enable` low from that same edge.
- The timer clears on entry to ARMED.
  - A ballot armed at edge k lapses at edge k+`TIMEOUT` if no vote is accepted.
  - A vote rising on the lapse edge wins: it is counted as cast, not lapsed.
- Poll close has priority over vote, timeout and ballot request on the same edge.
- Reset mid-ballot drops `enable` and `vote_inc` at the reset edge. No count is recorded.
- Counter saturation: increments while a counter is at all-ones leave it unchanged. `vote_inc` still pulses.

## Structure
- `evm_pkg` holds:
  - the state enum `evm_state_t` (CLOSED, IDLE, ARMED, HOLD);
  - default constants `EVM_N_CAND`, `EVM_CNT_W`, `EVM_TIMEOUT`.
- Sub-module `evm_sat_counter`: a `CNT_W` saturating counter with `inc` input and synchronous active-low reset. It is instantiated three times, once per audit count.
- The FSM, timer and edge registers live in the top module.

## Test plan
- Reset, open poll, pulse `ballot_req`, raise `vote`=01 three cycles later. Required:
  - `enable` rises one edge after the request;
  - `vote_inc`=01 for exactly one cycle;
  - `ballot_cnt`=1, `cast_cnt`=1.
- Arm a ballot, then raise `vote`=11 in one cycle, then `vote`=10 alone after releasing both. Required:
  - `multi_err` pulses once;
  - `vote_inc`=10 is counted;
  - `cast_cnt`=1.
- Arm a ballot and give no vote. Required:
  - `enable` falls exactly 16 edges after arming;
  - `lapse_cnt`=1, `vote_inc` never asserts.
- Hold `vote`=01 through the lapse, then pulse `ballot_req` while it is still held. Required:
  - no re-arm until `vote`=0;
  - the next ballot arms normally after release.
- Arm a ballot, then drop `voting_status` on the same edge a vote rises. Required:
  - state CLOSED, no `vote_inc`;
  - `lapse_cnt`=1, `cast_cnt`=0.
- Run 17 complete ballots with votes. Required: `ballot_cnt`=`cast_cnt`=15 (saturated) while `vote_inc` pulses 17 times.
